// File: rtl/core_l1i_cache_if.sv
// Fetch-side and memory-side signal bundle for core_l1i_cache.
// master drives the cache inputs (fetch stage + memory); slave is the cache itself.
interface core_l1i_cache_if;
  logic [31:0] l1i_addr_in;
  logic        l1i_val_in;
  logic        l1i_inv_in;
  logic        l1i_ack_out;
  logic [31:0] l1i_rdata_out;
  logic        l1i_stall_out;
  logic        mem_req_val_out;
  logic [31:0] mem_req_addr_out;
  logic        mem_req_ack_in;
  logic        mem_resp_val_in;
  logic [31:0] mem_resp_data_in;
  logic [31:0] stat_hit_out;
  logic [31:0] stat_miss_out;

  modport master (
    output l1i_addr_in, l1i_val_in, l1i_inv_in,
    output mem_req_ack_in, mem_resp_val_in, mem_resp_data_in,
    input  l1i_ack_out, l1i_rdata_out, l1i_stall_out,
    input  mem_req_val_out, mem_req_addr_out,
    input  stat_hit_out, stat_miss_out
  );

  modport slave (
    input  l1i_addr_in, l1i_val_in, l1i_inv_in,
    input  mem_req_ack_in, mem_resp_val_in, mem_resp_data_in,
    output l1i_ack_out, l1i_rdata_out, l1i_stall_out,
    output mem_req_val_out, mem_req_addr_out,
    output stat_hit_out, stat_miss_out
  );
endinterface

// File: rtl/core_l1i_cache.sv
// Direct-mapped read-only L1 I-cache: hits ack next cycle; misses stall fetch and refill one line (req/ack + beats).
// Define CORE_L1I_STATS_EN to add 32-bit hit/miss counters; otherwise the stat outputs are tied to 0.
module core_l1i_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  core_l1i_cache_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [29:0]          addr_q;
  logic [OFF_W-1:0]     cnt_q;
  logic                 inv_pend_q;
  logic                 ack_q;
  logic [31:0]          rdata_q;

  logic [OFF_W-1:0] in_off, lat_off;
  logic [IDX_W-1:0] in_idx, lat_idx;
  logic [TAG_W-1:0] in_tag, lat_tag;
  logic             is_idle, hit_c, fire_hit, start_miss, beat, last_beat;
  logic             unused_addr_lsb;

  assign in_off  = bus.l1i_addr_in[OFF_W+1:2];
  assign in_idx  = bus.l1i_addr_in[OFF_W+2 +: IDX_W];
  assign in_tag  = bus.l1i_addr_in[31 -: TAG_W];
  assign lat_off = addr_q[OFF_W-1:0];
  assign lat_idx = addr_q[OFF_W +: IDX_W];
  assign lat_tag = addr_q[29 -: TAG_W];
  assign unused_addr_lsb = ^bus.l1i_addr_in[1:0];

  // Invalidate wins over a same-cycle lookup, so that request is forced down the miss path.
  assign is_idle    = (state_q == IDLE);
  assign hit_c      = bus.l1i_val_in & ~bus.l1i_inv_in & valid_q[in_idx] & (tag_q[in_idx] == in_tag);
  assign fire_hit   = is_idle & hit_c;
  assign start_miss = is_idle & bus.l1i_val_in & ~hit_c;
  assign beat       = (state_q == REFILL) & bus.mem_resp_val_in;
  assign last_beat  = beat & (cnt_q == LAST_WORD);

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_miss)         state_d = MISS_REQ;
      MISS_REQ: if (bus.mem_req_ack_in) state_d = REFILL;
      REFILL:   if (last_beat)          state_d = RESP;
      RESP:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_val_out  = 1'b0;
    bus.mem_req_addr_out = '0;
    bus.l1i_stall_out    = ~is_idle | start_miss;
    if (state_q == MISS_REQ) begin
      bus.mem_req_val_out  = 1'b1;
      bus.mem_req_addr_out = {addr_q[29:OFF_W], {(OFF_W+2){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      valid_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      if (fire_hit) begin
        ack_q   <= 1'b1;
        rdata_q <= data_q[in_idx][in_off];
      end
      if (is_idle && bus.l1i_inv_in) valid_q <= '0;
      if (start_miss) addr_q <= bus.l1i_addr_in[31:2];
      if (state_q == MISS_REQ && bus.mem_req_ack_in) cnt_q <= '0;
      if (beat) cnt_q <= cnt_q + 1'b1;
      // Ack is raised on the final beat edge so it is visible during RESP; the wanted word may be this beat.
      if (last_beat) begin
        valid_q[lat_idx] <= 1'b1;
        ack_q            <= 1'b1;
        rdata_q          <= (lat_off == cnt_q) ? bus.mem_resp_data_in : data_q[lat_idx][lat_off];
      end
      if (!is_idle && bus.l1i_inv_in) inv_pend_q <= 1'b1;
      if (state_q == RESP) begin
        inv_pend_q <= 1'b0;
        if (inv_pend_q || bus.l1i_inv_in) valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat)      data_q[lat_idx][cnt_q] <= bus.mem_resp_data_in;
    if (last_beat) tag_q[lat_idx]         <= lat_tag;
  end

  assign bus.l1i_ack_out   = ack_q;
  assign bus.l1i_rdata_out = rdata_q;

`ifdef CORE_L1I_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      if (fire_hit)   stat_hit_q  <= stat_hit_q + 32'd1;
      if (start_miss) stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign bus.stat_hit_out  = stat_hit_q;
  assign bus.stat_miss_out = stat_miss_q;
`else
  assign bus.stat_hit_out  = '0;
  assign bus.stat_miss_out = '0;
`endif
endmodule

// File: tb/tb_core_l1i_cache.sv
// Randomized bench for core_l1i_cache against a line-level cache model and a procedural memory responder.
module tb_core_l1i_cache;
  localparam int LW   = 4;
  localparam int NL   = 16;
  localparam int OFFW = $clog2(LW);
  localparam int IDXW = $clog2(NL);

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  core_l1i_cache_if bus();

  core_l1i_cache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory: explicit words where a test wants known data, a fixed hash elsewhere.
  logic [31:0] mem_over [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (mem_over.exists(w)) return mem_over[w];
    return (w * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Reference model: which memory line each cache slot currently holds.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  int unsigned m_hits, m_misses;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / (4 * LW)) % NL;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (4 * LW * NL);
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  int          ack_dly = 0;
  int          gap_max = 0;
  int          last_hs = 0;
  int          last_beats = 0;
  int          unstable = 0;
  logic [31:0] req_log [$];

  task automatic serve();
    logic [31:0] line;
    int g;
    line = bus.mem_req_addr_out;
    req_log.push_back(line);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      if (!n_rst) return;
      if (bus.mem_req_addr_out !== line || bus.mem_req_val_out !== 1'b1) unstable++;
    end
    bus.mem_req_ack_in = 1'b1;
    @(negedge clk);
    bus.mem_req_ack_in = 1'b0;
    if (!n_rst) return;
    last_beats = 0;
    for (int w = 0; w < LW; w++) begin
      g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
      for (int i = 0; i < g; i++) begin
        last_beats++;
        @(negedge clk);
        if (!n_rst) return;
      end
      bus.mem_resp_val_in  = 1'b1;
      bus.mem_resp_data_in = mem_word(line + 32'(4 * w));
      last_beats++;
      @(negedge clk);
      bus.mem_resp_val_in = 1'b0;
      if (!n_rst) return;
    end
    last_hs = ack_dly + 1;
  endtask

  initial begin
    bus.mem_req_ack_in   = 1'b0;
    bus.mem_resp_val_in  = 1'b0;
    bus.mem_resp_data_in = '0;
    forever begin
      @(negedge clk);
      if (n_rst && bus.mem_req_val_out === 1'b1) serve();
    end
  end

  // Issues one fetch (called at negedge+1) and checks hit/miss behaviour, data, latency and fill address.
  task automatic fetch(input logic [31:0] a, input bit inv_same, input bit inv_mid);
    int unsigned ix, tg;
    bit          exp_hit, got, stall_ok;
    int          k, inj;
    logic [31:0] line_exp, seen;
    ix       = idx_of(a);
    tg       = tag_of(a);
    exp_hit  = !inv_same && m_valid[ix] && (m_tag[ix] == tg);
    line_exp = a & ~32'(4 * LW - 1);
    bus.l1i_addr_in = a;
    bus.l1i_val_in  = 1'b1;
    bus.l1i_inv_in  = inv_same;
    #1;
    chk("stall_on_request", 32'(bus.l1i_stall_out), 32'(!exp_hit));
    if (exp_hit) begin
      @(negedge clk); #1;
      bus.l1i_val_in = 1'b0;
      chk("hit_ack", 32'(bus.l1i_ack_out), 32'd1);
      chk("hit_rdata", bus.l1i_rdata_out, mem_word(a));
      chk("hit_no_memreq", 32'(bus.mem_req_val_out), 32'd0);
      m_hits++;
      return;
    end
    k = 0; got = 1'b0; stall_ok = 1'b1; inj = 0;
    while (!got && k < 300) begin
      @(negedge clk); #1;
      k++;
      if (k == 1) bus.l1i_inv_in = 1'b0;
      if (inv_mid) begin
        if (inj == 1) begin
          bus.l1i_inv_in = 1'b0;
          inj = 2;
        end else if (inj == 0 && bus.mem_resp_val_in) begin
          bus.l1i_inv_in = 1'b1;
          inj = 1;
        end
      end
      if (bus.l1i_stall_out !== 1'b1) stall_ok = 1'b0;
      if (bus.l1i_ack_out === 1'b1) got = 1'b1;
    end
    bus.l1i_val_in = 1'b0;
    bus.l1i_inv_in = 1'b0;
    chk("miss_ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("miss_latency", 32'(k), 32'(last_hs + last_beats + 1));
      chk("miss_rdata", bus.l1i_rdata_out, mem_word(a));
      chk("miss_stall_held", 32'(stall_ok), 32'd1);
      seen = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF;
      if (req_log.size() > 0) req_log.delete(0);
      chk("fill_addr", seen, line_exp);
    end
    if (inv_same) model_clear();
    m_valid[ix] = 1'b1;
    m_tag[ix]   = tg;
    if (inv_mid && inj > 0) model_clear();
    m_misses++;
    @(negedge clk); #1;
    chk("ack_pulse", 32'(bus.l1i_ack_out), 32'd0);
    chk("idle_no_stall", 32'(bus.l1i_stall_out), 32'd0);
  endtask

  task automatic check_stats();
`ifdef CORE_L1I_STATS_EN
    chk("stat_hit", bus.stat_hit_out, m_hits);
    chk("stat_miss", bus.stat_miss_out, m_misses);
`else
    chk("stat_hit_tied", bus.stat_hit_out, 32'd0);
    chk("stat_miss_tied", bus.stat_miss_out, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] a;
    int k;
    bus.l1i_addr_in = '0;
    bus.l1i_val_in  = 1'b0;
    bus.l1i_inv_in  = 1'b0;
    for (int w = 0; w < LW; w++) begin
      mem_over[32'h200 + 32'(4 * w)] = 32'hA0 + 32'(w);
      mem_over[32'h3C0 + 32'(4 * w)] = 32'hB0 + 32'(w);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", 32'(bus.l1i_ack_out), 32'd0);
    chk("rst_rdata", bus.l1i_rdata_out, 32'd0);
    chk("rst_memreq_val", 32'(bus.mem_req_val_out), 32'd0);
    chk("rst_memreq_addr", bus.mem_req_addr_out, 32'd0);
    chk("rst_stall", 32'(bus.l1i_stall_out), 32'd0);
    model_clear();
    m_hits = 0;
    m_misses = 0;
    check_stats();
    n_rst = 1'b1;
    @(negedge clk); #1;

    // Cold miss with a slow ack, then the rest of the line as back-to-back hits.
    ack_dly = 2; gap_max = 0;
    fetch(32'h200, 1'b0, 1'b0);
    gap_max = 1;
    fetch(32'h204, 1'b0, 1'b0);
    fetch(32'h208, 1'b0, 1'b0);
    fetch(32'h20C, 1'b0, 1'b0);

    // Mid-line miss, then a conflicting tag on index 0 and the re-miss of the evicted line.
    ack_dly = 0;
    fetch(32'h3C8, 1'b0, 1'b0);
    fetch(32'h600, 1'b0, 1'b0);
    fetch(32'h200, 1'b0, 1'b0);

    // Invalidate during refill, then a same-cycle invalidate and request.
    ack_dly = 1; gap_max = 2;
    fetch(32'h110, 1'b0, 1'b1);
    fetch(32'h110, 1'b0, 1'b0);
    fetch(32'h114, 1'b1, 1'b0);
    check_stats();

    // Reset in the middle of a refill.
    ack_dly = 0; gap_max = 2;
    bus.l1i_addr_in = 32'h440;
    bus.l1i_val_in  = 1'b1;
    k = 0;
    while (bus.mem_resp_val_in !== 1'b1 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("refill_reached", 32'(bus.mem_resp_val_in), 32'd1);
    n_rst = 1'b0;
    bus.l1i_val_in = 1'b0;
    @(negedge clk); #1;
    chk("midrst_ack", 32'(bus.l1i_ack_out), 32'd0);
    chk("midrst_stall", 32'(bus.l1i_stall_out), 32'd0);
    chk("midrst_memreq", 32'(bus.mem_req_val_out), 32'd0);
    model_clear();
    m_hits = 0;
    m_misses = 0;
    req_log.delete();
    check_stats();
    n_rst = 1'b1;
    @(negedge clk); #1;
    fetch(32'h440, 1'b0, 1'b0);
    fetch(32'h444, 1'b0, 1'b0);
    fetch(32'h448, 1'b0, 1'b0);
    fetch(32'h440, 1'b0, 1'b0);
    check_stats();

    // Random traffic over three tags so indexes conflict often.
    for (int n = 0; n < 80; n++) begin
      int ts;
      ts = int'($urandom_range(0, 2));
      a = (32'((ts == 0) ? 1 : (ts == 1) ? 3 : 9) << (2 + OFFW + IDXW))
        | (32'($urandom_range(0, NL - 1)) << (2 + OFFW))
        | (32'($urandom_range(0, LW - 1)) << 2)
        | 32'($urandom_range(0, 3));
      ack_dly = int'($urandom_range(0, 3));
      gap_max = int'($urandom_range(0, 2));
      fetch(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); #1;
      end
    end
    check_stats();
    chk("req_stable", 32'(unstable), 32'd0);
    chk("req_log_drained", 32'(req_log.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
